// File: rtl/median_frame_sequencer.sv
// Frame-level sequencer for the binary median filter: streams one raster frame into the
// filter's image memory, then runs the filter under a watchdog while counting foreground writes.
module median_frame_sequencer #(
  parameter int unsigned IMG_W       = 240,
  parameter int unsigned IMG_H       = 180,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned THR_W       = 13,
  parameter int unsigned START_GAP   = 2,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frameGo,
  input  logic [THR_W-1:0]  cfgThreshold,
  input  logic              pixValid,
  input  logic              pixData,
  output logic              pixReady,
  output logic              writeMem,
  output logic [ADDR_W-1:0] xAddressIn,
  output logic [ADDR_W-1:0] yAddressIn,
  output logic              dataIn,
  output logic              start,
  output logic [THR_W-1:0]  threshold,
  input  logic              writeMedianMem,
  input  logic              writeMedianData,
  input  logic              fullImageDone,
  output logic              busy,
  output logic              frameDone,
  output logic              timeoutErr,
  output logic [15:0]       fgCount
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int unsigned GAP_W = (START_GAP >= 1) ? $clog2(START_GAP + 1) : 1;
  localparam int unsigned WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] x_cnt, x_nxt;
  logic [ADDR_W-1:0] y_cnt, y_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic [WD_W-1:0]   wd_cnt, wd_nxt;

  logic              ready_nxt;
  logic              write_nxt;
  logic [ADDR_W-1:0] xa_nxt;
  logic [ADDR_W-1:0] ya_nxt;
  logic              data_nxt;
  logic              start_nxt;
  logic [THR_W-1:0]  thr_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic              err_nxt;
  logic [15:0]       fg_nxt;

  logic handshake;
  assign handshake = pixValid & pixReady;

  // Next-state and next-output logic; level outputs follow the state being entered.
  always_comb begin
    state_nxt = state;
    x_nxt     = x_cnt;
    y_nxt     = y_cnt;
    gap_nxt   = gap_cnt;
    wd_nxt    = wd_cnt;
    write_nxt = 1'b0;
    xa_nxt    = xAddressIn;
    ya_nxt    = yAddressIn;
    data_nxt  = dataIn;
    thr_nxt   = threshold;
    done_nxt  = 1'b0;
    err_nxt   = timeoutErr;
    fg_nxt    = fgCount;

    case (state)
      S_IDLE: begin
        if (frameGo) begin
          state_nxt = S_LOAD;
          thr_nxt   = cfgThreshold;
          fg_nxt    = 16'd0;
          err_nxt   = 1'b0;
          x_nxt     = '0;
          y_nxt     = '0;
        end
      end
      S_LOAD: begin
        if (handshake) begin
          write_nxt = 1'b1;
          xa_nxt    = x_cnt;
          ya_nxt    = y_cnt;
          data_nxt  = pixData;
          // Column-major scan: y runs fastest, x advances on each y wrap.
          if (y_cnt == ADDR_W'(IMG_H - 1)) begin
            y_nxt = '0;
            if (x_cnt == ADDR_W'(IMG_W - 1)) begin
              x_nxt     = '0;
              gap_nxt   = '0;
              state_nxt = S_GAP;
            end else begin
              x_nxt = x_cnt + ADDR_W'(1);
            end
          end else begin
            y_nxt = y_cnt + ADDR_W'(1);
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_W'(START_GAP)) begin
          state_nxt = S_RUN;
          wd_nxt    = '0;
        end else begin
          gap_nxt = gap_cnt + GAP_W'(1);
        end
      end
      S_RUN: begin
        if (writeMedianMem && writeMedianData && (fgCount != 16'hFFFF)) begin
          fg_nxt = fgCount + 16'd1;
        end
        // Completion takes priority over a coincident watchdog expiry.
        if (fullImageDone) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end else begin
          wd_nxt = wd_cnt + WD_W'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    ready_nxt = (state_nxt == S_LOAD);
    start_nxt = (state_nxt == S_RUN);
    busy_nxt  = (state_nxt != S_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      x_cnt      <= '0;
      y_cnt      <= '0;
      gap_cnt    <= '0;
      wd_cnt     <= '0;
      pixReady   <= 1'b0;
      writeMem   <= 1'b0;
      xAddressIn <= '0;
      yAddressIn <= '0;
      dataIn     <= 1'b0;
      start      <= 1'b0;
      threshold  <= '0;
      busy       <= 1'b0;
      frameDone  <= 1'b0;
      timeoutErr <= 1'b0;
      fgCount    <= 16'd0;
    end else begin
      state      <= state_nxt;
      x_cnt      <= x_nxt;
      y_cnt      <= y_nxt;
      gap_cnt    <= gap_nxt;
      wd_cnt     <= wd_nxt;
      pixReady   <= ready_nxt;
      writeMem   <= write_nxt;
      xAddressIn <= xa_nxt;
      yAddressIn <= ya_nxt;
      dataIn     <= data_nxt;
      start      <= start_nxt;
      threshold  <= thr_nxt;
      busy       <= busy_nxt;
      frameDone  <= done_nxt;
      timeoutErr <= err_nxt;
      fgCount    <= fg_nxt;
    end
  end

endmodule

// File: tb/tb_median_frame_sequencer.sv
// Randomized scoreboard bench for median_frame_sequencer on a reduced frame size,
// with directed timing checks around load, gap, run, watchdog and mid-frame reset.
module tb_median_frame_sequencer;

  localparam int unsigned IMG_W = 20;
  localparam int unsigned IMG_H = 15;
  localparam int unsigned GAP   = 2;
  localparam int unsigned TO    = 16;
  localparam int          NPIX  = IMG_W * IMG_H;

  logic        clk = 1'b0;
  logic        reset;
  logic        frameGo;
  logic [12:0] cfgThreshold;
  logic        pixValid;
  logic        pixData;
  logic        pixReady;
  logic        writeMem;
  logic [7:0]  xAddressIn;
  logic [7:0]  yAddressIn;
  logic        dataIn;
  logic        start;
  logic [12:0] threshold;
  logic        writeMedianMem;
  logic        writeMedianData;
  logic        fullImageDone;
  logic        busy;
  logic        frameDone;
  logic        timeoutErr;
  logic [15:0] fgCount;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_wr = 0;
  int first_wr_cyc = -1;
  int last_wr_cyc = -1;
  logic [31:0] sb[$];
  logic [31:0] mon_exp;

  median_frame_sequencer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(8), .THR_W(13),
    .START_GAP(GAP), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset), .frameGo(frameGo), .cfgThreshold(cfgThreshold),
    .pixValid(pixValid), .pixData(pixData), .pixReady(pixReady),
    .writeMem(writeMem), .xAddressIn(xAddressIn), .yAddressIn(yAddressIn),
    .dataIn(dataIn), .start(start), .threshold(threshold),
    .writeMedianMem(writeMedianMem), .writeMedianData(writeMedianData),
    .fullImageDone(fullImageDone), .busy(busy), .frameDone(frameDone),
    .timeoutErr(timeoutErr), .fgCount(fgCount)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: the k-th accepted pixel lands at x = k / IMG_H, y = k % IMG_H.
  function automatic logic [31:0] exp_wr(input int k, input logic d);
    int x;
    int y;
    x = k / IMG_H;
    y = k % IMG_H;
    return {15'd0, 8'(x), 8'(y), d};
  endfunction

  // Monitor: every write strobe must match the oldest accepted pixel.
  always @(negedge clk) begin
    if (reset && writeMem) begin
      n_wr++;
      last_wr_cyc = cyc;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      check("wr_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        mon_exp = sb.pop_front();
        check("wr_addr_data", {15'd0, xAddressIn, yAddressIn, dataIn}, mon_exp);
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, 32'({pixReady, writeMem, dataIn, start, busy, frameDone, timeoutErr}), 32'd0);
    check({tag, "_addr_thr"}, {3'd0, xAddressIn, yAddressIn, threshold}, 32'd0);
    check({tag, "_fg"}, 32'(fgCount), 32'd0);
  endtask

  task automatic frame_load(input logic [12:0] thr, input int pct, input int stop_at,
                            input bit noise, output int n, output int m);
    int k;
    int it;
    k = 0;
    it = 0;
    m = -1;
    n_wr = 0;
    first_wr_cyc = -1;
    @(posedge clk); #1;
    frameGo = 1'b1;
    cfgThreshold = thr;
    n = cyc;
    while (k < stop_at && it < 20 * stop_at + 100) begin
      @(posedge clk); #1;
      frameGo = (it == 9);
      cfgThreshold = 13'($urandom);
      pixValid = (int'($urandom_range(99)) < pct);
      pixData = 1'($urandom_range(1));
      if (noise) begin
        writeMedianMem = 1'($urandom_range(1));
        writeMedianData = 1'b1;
        fullImageDone = 1'($urandom_range(1));
      end
      @(negedge clk);
      if (it == 0) begin
        check("go_busy", 32'(busy), 32'd1);
        check("go_ready", 32'(pixReady), 32'd1);
        check("go_err_clear", 32'(timeoutErr), 32'd0);
        check("go_fg_clear", 32'(fgCount), 32'd0);
      end
      if (pixValid && pixReady) begin
        sb.push_back(exp_wr(k, pixData));
        k++;
        m = cyc;
      end
      it++;
    end
    if (k < stop_at) check("load_budget", 32'(k), 32'(stop_at));
  endtask

  task automatic post_load(input int m, input int nexp, input logic [12:0] thr, output int s);
    @(posedge clk); #1;
    frameGo = 1'b0;
    pixValid = 1'b1;
    writeMedianMem = 1'b0;
    fullImageDone = 1'b0;
    @(negedge clk);
    check("ready_drop", 32'(pixReady), 32'd0);
    s = -1;
    for (int i = 0; i < 40 && s < 0; i++) begin
      @(negedge clk);
      if (start) s = cyc;
    end
    check("start_cycle", 32'(s), 32'(m + 2 + int'(GAP)));
    check("wr_count", 32'(n_wr), 32'(nexp));
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("thr_run", 32'(threshold), 32'(thr));
    check("fg_at_start", 32'(fgCount), 32'd0);
  endtask

  task automatic run_phase(input int ones, input int zeros, input logic [12:0] thr);
    bit q[$];
    bit t;
    int j;
    for (int i = 0; i < ones; i++) q.push_back(1'b1);
    for (int i = 0; i < zeros; i++) q.push_back(1'b0);
    for (int i = q.size() - 1; i > 0; i--) begin
      j = int'($urandom_range(i));
      t = q[i]; q[i] = q[j]; q[j] = t;
    end
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk); #1;
      pixValid = 1'b0;
      writeMedianMem = 1'b1;
      writeMedianData = q[i];
      frameGo = (i == q.size() / 2);
      cfgThreshold = 13'($urandom);
    end
    @(posedge clk); #1;
    writeMedianMem = 1'b0;
    frameGo = 1'b0;
    fullImageDone = 1'b1;
    @(posedge clk); #1;
    fullImageDone = 1'b0;
    writeMedianMem = 1'b1;
    writeMedianData = 1'b1;
    @(negedge clk);
    check("done_pulse", 32'(frameDone), 32'd1);
    check("done_start_low", 32'(start), 32'd0);
    check("done_busy", 32'(busy), 32'd1);
    check("done_fg", 32'(fgCount), 32'(ones));
    @(posedge clk); #1;
    writeMedianMem = 1'b0;
    @(negedge clk);
    check("done_single", 32'(frameDone), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_fg_hold", 32'(fgCount), 32'(ones));
    check("idle_thr_hold", 32'(threshold), 32'(thr));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    int m;
    int s;
    int f;
    int ones;
    logic [12:0] thr;
    reset = 1'b0;
    frameGo = 1'b0;
    cfgThreshold = '0;
    pixValid = 1'b0;
    pixData = 1'b0;
    writeMedianMem = 1'b0;
    writeMedianData = 1'b0;
    fullImageDone = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("por");
    reset = 1'b1;

    // Back-to-back frame, threshold 50, 7 foreground and 3 background median writes.
    frame_load(13'd50, 100, NPIX, 1'b0, n, m);
    post_load(m, NPIX, 13'd50, s);
    check("first_wr_cycle", 32'(first_wr_cyc), 32'(n + 2));
    check("last_wr_cycle", 32'(last_wr_cyc), 32'(m + 1));
    check("load_length", 32'(m - n), 32'(NPIX));
    run_phase(7, 3, 13'd50);

    // Bubbled frame with median strobes and done pulses injected outside RUN.
    thr = 13'($urandom);
    ones = int'($urandom_range(10));
    frame_load(thr, 50, NPIX, 1'b1, n, m);
    post_load(m, NPIX, thr, s);
    run_phase(ones, 10 - ones, thr);

    // Watchdog expiry with no completion.
    thr = 13'($urandom);
    frame_load(thr, 100, NPIX, 1'b0, n, m);
    post_load(m, NPIX, thr, s);
    f = -1;
    for (int i = 0; i < 40 && f < 0; i++) begin
      @(negedge clk);
      if (!start) f = cyc;
    end
    check("timeout_cycle", 32'(f), 32'(s + int'(TO)));
    check("timeout_err", 32'(timeoutErr), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_no_done", 32'(frameDone), 32'd0);

    // Completion on the very cycle the watchdog would expire.
    thr = 13'($urandom);
    frame_load(thr, 80, NPIX, 1'b0, n, m);
    post_load(m, NPIX, thr, s);
    while (cyc < s + int'(TO) - 1) begin
      @(posedge clk); #1;
      pixValid = 1'b0;
    end
    fullImageDone = 1'b1;
    @(posedge clk); #1;
    fullImageDone = 1'b0;
    @(negedge clk);
    check("race_done", 32'(frameDone), 32'd1);
    check("race_no_err", 32'(timeoutErr), 32'd0);
    check("race_start_low", 32'(start), 32'd0);
    @(negedge clk);
    check("race_err_idle", 32'(timeoutErr), 32'd0);

    // Reset in the middle of a load abandons the frame.
    frame_load(13'd77, 70, 150, 1'b0, n, m);
    @(posedge clk); #1;
    pixValid = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_zero("midrst");
    check("midrst_sb", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Fresh frame after reset must restart at (0,0).
    thr = 13'($urandom);
    ones = int'($urandom_range(10));
    frame_load(thr, 60, NPIX, 1'b0, n, m);
    post_load(m, NPIX, thr, s);
    run_phase(ones, 10 - ones, thr);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/median_frame_sequencer.md
# median_frame_sequencer

Frame-level controller for the binary median filter core. Accepts a raster pixel stream over a valid/ready handshake and writes it into the filter's input image memory, generating the write strobe and x/y addresses. It then waits a fixed gap, raises the filter's start and supplies the threshold. It holds start until the filter reports completion or a watchdog expires, counting foreground median writes along the way. It sits between the frame source and the median filter top and is the only driver of the filter's load/start inputs.

## Interface
- IMG_W, 240, image width; x address range 0..IMG_W-1
- IMG_H, 180, image height; y address range 0..IMG_H-1
- ADDR_W, 8, x/y address width
- THR_W, 13, threshold width
- START_GAP, 2, idle cycles between last memory write and start assertion (≥1)
- TIMEOUT_CYC, 1000000, RUN-state watchdog limit in cycles
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- frameGo  input  1  single-cycle request to process one frame; honoured only in IDLE
- cfgThreshold  input  THR_W  threshold; sampled on accepted frameGo
- pixValid  input  1  source has a pixel
- pixData  input  1  binary pixel value
- pixReady  output  1  sequencer accepts a pixel this cycle
- writeMem  output  1  filter image-memory write strobe
- xAddressIn  output  ADDR_W  write x address
- yAddressIn  output  ADDR_W  write y address
- dataIn  output  1  write data
- start  output  1  filter run level
- threshold  output  THR_W  latched threshold to filter
- writeMedianMem  input  1  filter median-memory write strobe
- writeMedianData  input  1  filter median-memory write data
- fullImageDone  input  1  filter completion flag
- busy  output  1  state ≠ IDLE
- frameDone  output  1  one-cycle pulse on successful completion
- timeoutErr  output  1  sticky watchdog error
- fgCount  output  16  count of writeMedianMem strobes with writeMedianData=1 in the last/current run

## Operation
- States: IDLE, LOAD, GAP, RUN, DONE.
- IDLE: pixReady=0, start=0. On frameGo: latch cfgThreshold into threshold, clear fgCount, clear timeoutErr, clear x/y counters to 0, go LOAD.
- LOAD: pixReady=1. Each handshake (pixValid&pixReady) registers writeMem=1, xAddressIn=x, yAddressIn=y, dataIn=pixData for exactly the next cycle. No handshake means writeMem=0 next cycle, and addresses/data hold.
- Scan order: y fastest. On each handshake y increments. When y=IMG_H-1, y wraps to 0 and x increments.
- The handshake at x=IMG_W-1, y=IMG_H-1 is the last one. pixReady drops the following cycle, and the state goes to GAP.
- GAP: writeMem=0. A gap counter runs START_GAP cycles after the last write strobe, then the state goes to RUN.
- RUN: start=1 (level), watchdog counting from 0. Each writeMedianMem=1 with writeMedianData=1 increments fgCount, saturating at 65535.
- RUN exits:
  - fullImageDone=1 → DONE.
  - Watchdog reaching TIMEOUT_CYC-1 → timeoutErr=1, IDLE.
  - If both occur in the same cycle, done wins.
- DONE: start=0, frameDone=1 for one cycle, then IDLE.
- Ignored inputs:
  - frameGo outside IDLE.
  - fullImageDone outside RUN.
  - writeMedianMem outside RUN, which is not counted.
- fgCount and threshold hold their values in IDLE until the next accepted frameGo.

## Timing
- Reset value of every output is 0: pixReady, writeMem, xAddressIn, yAddressIn, dataIn, start, threshold, busy, frameDone, timeoutErr, fgCount. State resets to IDLE.
- Reset is asynchronous on assert and released synchronously to clk.
- Reset mid-frame abandons the frame. No partial state survives.
- frameGo in cycle N: busy=1 and pixReady=1 from N+1.
- Handshake in cycle K: writeMem/addresses/data are valid in cycle K+1. There is no back-pressure toward the filter memory.
- Last handshake in cycle M: last writeMem in cycle M+1, pixReady=0 from M+1, start=1 from cycle M+2+START_GAP.
- With back-to-back pixels, a full frame loads in IMG_W·IMG_H cycles.
- fullImageDone sampled high in cycle D: start=0 and frameDone=1 in D+1, busy=0 in D+2.
- Watchdog: with start rising in cycle S and no done, timeoutErr=1 and start=0 in cycle S+TIMEOUT_CYC.

## Test plan
- Full frame, pixValid always 1, START_GAP=2, threshold 50:
  - 43200 write strobes; first strobe at (0,0) in cycle N+2; strobe 180 at (1,0); last at (239,179).
  - start rises 3 cycles after the last strobe and threshold=50 during RUN.
- Random pixValid bubbles (50%):
  - writeMem count equals handshake count.
  - No address skipped or repeated; dataIn matches each pixData.
  - pixReady low after the 43200th handshake.
- In RUN:
  - 7 strobes with writeMedianData=1 and 3 with 0, then fullImageDone → fgCount=7, frameDone single pulse, busy drops 2 cycles after done.
  - frameGo pulsed during LOAD and RUN → ignored, threshold unchanged.
- TIMEOUT_CYC=16, fullImageDone held 0 → timeoutErr=1 and start=0 exactly 16 cycles after start rises; next frameGo clears timeoutErr.
- Edge cases:
  - fullImageDone asserted in the watchdog-expiry cycle → frameDone=1, timeoutErr=0.
  - reset asserted at handshake 1000 → all outputs 0 immediately; a new frame restarts at (0,0).
